// File: rtl/fa_bist_if.sv
// Bundle of signals between the full-adder BIST controller and its
// environment: start request, operand drive, adder response and status.
interface fa_bist_if;
    logic       start;
    logic       A;
    logic       B;
    logic       Cin;
    logic       S;
    logic       Cout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] fail_vec;

    modport master (
        input  start, S, Cout,
        output A, B, Cin, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, S, Cout,
        input  A, B, Cin, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/fa_bist_ctrl.sv
// Full-adder self-test controller: walks all eight {A,B,Cin} vectors,
// waits SETTLE cycles for the adder to respond, checks S/Cout and reports
// pass/err_count/fail_vec with a one-cycle done pulse.
// Optional macro FA_BIST_STOP_ON_FAIL_EN: end the pass on the first mismatch.
//
// state       | meaning
// IDLE        | waiting for start, operands driven to 0
// DRIVE       | operands take the current vector
// SETTLE_WAIT | operands held while the adder settles (SETTLE cycles)
// CHECK       | response compared against the expected sum/carry
// FINISH      | done pulse, pass result valid
module fa_bist_ctrl #(
    parameter int SETTLE = 2
) (
    input logic         clk,
    input logic         rst,
    fa_bist_if.master   bus
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DRIVE       = 3'd1;
    localparam logic [2:0] SETTLE_WAIT = 3'd2;
    localparam logic [2:0] CHECK       = 3'd3;
    localparam logic [2:0] FINISH      = 3'd4;

    logic [2:0] state;
    logic [2:0] vec;
    logic [2:0] abc;
    logic [3:0] cnt;
    logic [3:0] err_count;
    logic [2:0] fail_vec;
    logic       pass;

    logic       s_exp;
    logic       c_exp;
    logic       mismatch;
    logic       last;
    logic [3:0] err_next;

    // Expected adder response for the held vector and the pass-end decision.
    always_comb begin
        s_exp    = abc[2] ^ abc[1] ^ abc[0];
        c_exp    = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
        mismatch = (bus.S != s_exp) || (bus.Cout != c_exp);
        err_next = (mismatch && (err_count != 4'd15)) ? err_count + 4'd1 : err_count;
`ifdef FA_BIST_STOP_ON_FAIL_EN
        last     = (vec == 3'd7) || mismatch;
`else
        last     = (vec == 3'd7);
`endif
    end

    // Sequencer, vector/operand registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 3'd0;
            abc       <= 3'd0;
            cnt       <= 4'd0;
            err_count <= 4'd0;
            fail_vec  <= 3'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    // FINISH accepts start too, giving back-to-back passes.
                    if (bus.start) begin
                        state     <= DRIVE;
                        vec       <= 3'd0;
                        abc       <= 3'd0;
                        err_count <= 4'd0;
                        fail_vec  <= 3'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    state <= SETTLE_WAIT;
                    cnt   <= 4'(SETTLE - 1);
                end
                SETTLE_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && (err_count == 4'd0)) begin
                        fail_vec <= abc;
                    end
                    if (last) begin
                        state <= FINISH;
                        pass  <= (err_next == 4'd0);
                        abc   <= 3'd0;
                    end else begin
                        state <= DRIVE;
                        vec   <= vec + 3'd1;
                        abc   <= vec + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A         = abc[2];
    assign bus.B         = abc[1];
    assign bus.Cin       = abc[0];
    assign bus.busy      = (state == DRIVE) || (state == SETTLE_WAIT) || (state == CHECK);
    assign bus.done      = (state == FINISH);
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.fail_vec  = fail_vec;
endmodule

// File: doc/fa_bist_ctrl.md
FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles from applying a vector to sampling the result (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to run a self-test pass.
REQ-005 SHALL have port A  output  1  operand A driven to the adder under test.
REQ-006 SHALL have port B  output  1  operand B driven to the adder under test.
REQ-007 SHALL have port Cin  output  1  carry-in driven to the adder under test.
REQ-008 SHALL have port S  input  1  sum returned by the adder under test.
REQ-009 SHALL have port Cout  input  1  carry-out returned by the adder under test.
REQ-010 SHALL have port busy  output  1  high while a pass is running.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a pass ends.
REQ-012 SHALL have port pass  output  1  result of last completed pass (1 = no mismatch).
REQ-013 SHALL have port err_count  output  4  mismatching vectors in current/last pass.
REQ-014 SHALL have port fail_vec  output  3  {A,B,Cin} of first mismatching vector of the last pass.

Function
REQ-015 SHALL implement states IDLE, DRIVE, SETTLE_WAIT, CHECK, FINISH.
REQ-016 SHALL leave IDLE for DRIVE on the cycle after start sampled high; start ignored while busy.
REQ-017 SHALL, on entering a pass, clear err_count and the 3-bit vector counter vec to 0.
REQ-018 SHALL drive {A,B,Cin} = vec registered, in DRIVE and held stable through SETTLE_WAIT and CHECK.
REQ-019 SHALL stay in SETTLE_WAIT exactly SETTLE cycles, then enter CHECK.
REQ-020 SHALL, in CHECK, compare S to A^B^Cin and Cout to (A&B)|(A&Cin)|(B&Cin).
REQ-021 SHALL on mismatch increment err_count (saturating at 15), and latch fail_vec only on the first mismatch of the pass.
REQ-022 SHALL go CHECK -> DRIVE with vec+1 when vec < 7; CHECK -> FINISH when vec == 7 (no wrap to 0 mid-pass).
REQ-023 SHALL, in FINISH, pulse done for one cycle, set pass = (err_count == 0), return to IDLE.
REQ-024 SHALL hold busy high in DRIVE, SETTLE_WAIT, CHECK; low in IDLE and FINISH.
REQ-025 SHALL hold pass, err_count, fail_vec stable in IDLE until the next pass starts.
REQ-026 SHALL treat start asserted in the same cycle as done as a new request (back-to-back passes).
REQ-027 SHALL drive A, B, Cin = 0 in IDLE; a full pass takes 8 x (SETTLE + 2) + 1 cycles from start to done.

Reset
REQ-028 SHALL on rst high immediately force IDLE, vec=0, A=B=Cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-029 SHALL abort a pass in progress on rst with no done pulse; first start after rst release runs a full pass.

Configuration
REQ-030 SHALL support macro FA_BIST_STOP_ON_FAIL_EN.
REQ-031 SHALL, with FA_BIST_STOP_ON_FAIL_EN defined, go CHECK -> FINISH on the first mismatch (err_count = 1, pass = 0).
REQ-032 SHALL, without FA_BIST_STOP_ON_FAIL_EN, always test all 8 vectors.

Verification
REQ-033 SHALL cover: correct adder model, SETTLE=2, start pulse -> done after 33 cycles, pass=1, err_count=0.
REQ-034 SHALL cover: Cout stuck-at-0 -> pass=0, err_count=4, fail_vec=3'b011.
REQ-035 SHALL cover: S inverted, macro defined -> done after first CHECK, err_count=1, fail_vec=3'b000.
REQ-036 SHALL cover: rst asserted during vec=4 -> all outputs 0 asynchronously, no done; next start yields full 8-vector pass.
REQ-037 SHALL cover: start held high during busy -> ignored; start on done cycle -> second pass begins next cycle.
REQ-038 SHALL cover: SETTLE=1 and SETTLE=15 with correct adder -> done after 25 and 137 cycles, pass=1.
